// File: rtl/mainbus_arbiter.sv
// mainbus_arbiter: shares the JAM-1 main bus control fields between the CPU pipeline
// and one external bus master using req/gnt bursts with turnaround gaps and a CPU window.
module mainbus_arbiter #(
    parameter int CPU_MIN_CYCLES = 2,
    parameter int BURST_W        = 4
) (
    input  logic               clk,
    input  logic               reset_in,
    input  logic [3:0]         cpu_mainbus_assert,
    input  logic [3:0]         cpu_mainbus_load,
    input  logic [2:0]         cpu_xfer_assert,
    input  logic [3:0]         cpu_xfer_loaddec,
    input  logic [2:0]         cpu_addrsel,
    input  logic               cpu_lock,
    input  logic               dma_req,
    input  logic [BURST_W-1:0] dma_burst,
    input  logic [3:0]         dma_mainbus_assert,
    input  logic [3:0]         dma_mainbus_load,
    input  logic [2:0]         dma_addrsel,
    output logic               dma_gnt,
    output logic               dma_done,
    output logic               pipe_stall,
    output logic [3:0]         MainBus_Assert,
    output logic [3:0]         MainBus_Load,
    output logic [2:0]         Xfer_Assert,
    output logic [3:0]         Xfer_LoadDec,
    output logic [2:0]         AddrSel
);

    localparam logic [1:0] ST_CPU      = 2'd0;
    localparam logic [1:0] ST_HANDOVER = 2'd1;
    localparam logic [1:0] ST_DMA      = 2'd2;
    localparam logic [1:0] ST_RETURN   = 2'd3;

    localparam logic [3:0] WIN_LOAD = 4'(CPU_MIN_CYCLES);

    logic [1:0]         state_q, state_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [3:0]         win_cnt_q, win_cnt_d;

    // The burst length is latched when the grant is committed, so later changes are ignored.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        win_cnt_d   = win_cnt_q;
        case (state_q)
            ST_CPU: begin
                if (win_cnt_q != 4'd0) begin
                    win_cnt_d = win_cnt_q - 4'd1;
                end else if (dma_req && !cpu_lock) begin
                    state_d     = ST_HANDOVER;
                    burst_cnt_d = dma_burst;
                end
            end
            ST_HANDOVER: state_d = ST_DMA;
            ST_DMA: begin
                if (!dma_req || burst_cnt_q == '0) begin
                    state_d = ST_RETURN;
                end else begin
                    burst_cnt_d = burst_cnt_q - BURST_W'(1);
                end
            end
            ST_RETURN: begin
                state_d   = ST_CPU;
                win_cnt_d = WIN_LOAD;
            end
            default: state_d = ST_CPU;
        endcase
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q     <= ST_CPU;
            burst_cnt_q <= '0;
            win_cnt_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            win_cnt_q   <= win_cnt_d;
        end
    end

    // Outputs are qualified by reset_in so the bus goes quiet the instant reset asserts.
    always_comb begin
        dma_gnt        = 1'b0;
        dma_done       = 1'b0;
        pipe_stall     = 1'b0;
        MainBus_Assert = 4'd0;
        MainBus_Load   = 4'd0;
        Xfer_Assert    = 3'd0;
        Xfer_LoadDec   = 4'd0;
        AddrSel        = 3'd0;
        if (reset_in) begin
            case (state_q)
                ST_CPU: begin
                    MainBus_Assert = cpu_mainbus_assert;
                    MainBus_Load   = cpu_mainbus_load;
                    Xfer_Assert    = cpu_xfer_assert;
                    Xfer_LoadDec   = cpu_xfer_loaddec;
                    AddrSel        = cpu_addrsel;
                end
                ST_DMA: begin
                    dma_gnt        = 1'b1;
                    dma_done       = (burst_cnt_q == '0);
                    pipe_stall     = 1'b1;
                    MainBus_Assert = dma_mainbus_assert;
                    MainBus_Load   = dma_mainbus_load;
                    AddrSel        = dma_addrsel;
                end
                default: pipe_stall = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_mainbus_arbiter.sv
// tb_mainbus_arbiter: scoreboard bench; expected per-cycle bus ownership is queued as
// stimulus is driven and compared against the DUT outputs at the following falling edge.
module tb_mainbus_arbiter;

    typedef logic [20:0] obs_t;

    localparam int K_CPU  = 0;
    localparam int K_GAP  = 1;
    localparam int K_DMA  = 2;
    localparam int K_DONE = 3;
    localparam int K_ZERO = 4;

    logic       clk = 1'b0;
    logic       reset_in = 1'b0;
    logic [3:0] cpu_ma = 4'd0, cpu_ml = 4'd0, cpu_xl = 4'd0;
    logic [2:0] cpu_xa = 3'd0, cpu_as = 3'd0;
    logic       cpu_lock = 1'b0;
    logic       dma_req = 1'b0;
    logic [3:0] dma_burst = 4'd0;
    logic [3:0] dma_ma = 4'd0, dma_ml = 4'd0;
    logic [2:0] dma_as = 3'd0;
    logic       dma_gnt, dma_done, pipe_stall;
    logic [3:0] MainBus_Assert, MainBus_Load, Xfer_LoadDec;
    logic [2:0] Xfer_Assert, AddrSel;

    obs_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   hold_fields = 1'b0;

    mainbus_arbiter #(.CPU_MIN_CYCLES(2), .BURST_W(4)) dut (
        .clk(clk), .reset_in(reset_in),
        .cpu_mainbus_assert(cpu_ma), .cpu_mainbus_load(cpu_ml),
        .cpu_xfer_assert(cpu_xa), .cpu_xfer_loaddec(cpu_xl), .cpu_addrsel(cpu_as),
        .cpu_lock(cpu_lock), .dma_req(dma_req), .dma_burst(dma_burst),
        .dma_mainbus_assert(dma_ma), .dma_mainbus_load(dma_ml), .dma_addrsel(dma_as),
        .dma_gnt(dma_gnt), .dma_done(dma_done), .pipe_stall(pipe_stall),
        .MainBus_Assert(MainBus_Assert), .MainBus_Load(MainBus_Load),
        .Xfer_Assert(Xfer_Assert), .Xfer_LoadDec(Xfer_LoadDec), .AddrSel(AddrSel)
    );

    always #5 clk = ~clk;

    // Layout: {gnt, done, stall, MainBus_Assert, MainBus_Load, Xfer_Assert, Xfer_LoadDec, AddrSel}
    function automatic obs_t observe();
        return {dma_gnt, dma_done, pipe_stall, MainBus_Assert, MainBus_Load,
                Xfer_Assert, Xfer_LoadDec, AddrSel};
    endfunction

    function automatic obs_t expect_of(input int kind);
        case (kind)
            K_CPU:  return {3'b000, cpu_ma, cpu_ml, cpu_xa, cpu_xl, cpu_as};
            K_GAP:  return {3'b001, 18'd0};
            K_DMA:  return {3'b101, dma_ma, dma_ml, 3'd0, 4'd0, dma_as};
            K_DONE: return {3'b111, dma_ma, dma_ml, 3'd0, 4'd0, dma_as};
            default: return 21'd0;
        endcase
    endfunction

    // Nonzero random fields make a stuck-at-zero or swapped mux visible.
    task automatic drive_cycle(input bit req, input bit lock, input int kind);
        @(posedge clk);
        #1;
        dma_req  = req;
        cpu_lock = lock;
        if (!hold_fields) begin
            cpu_ma = 4'($urandom_range(1, 15));
            cpu_ml = 4'($urandom_range(1, 15));
            cpu_xa = 3'($urandom_range(1, 7));
            cpu_xl = 4'($urandom_range(1, 15));
            cpu_as = 3'($urandom_range(1, 7));
            dma_ma = 4'($urandom_range(1, 15));
            dma_ml = 4'($urandom_range(1, 15));
            dma_as = 3'($urandom_range(1, 7));
        end
        sb.push_back(expect_of(kind));
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t e, o;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 1'b0, K_ZERO);
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("[TB] FAIL reset cycle %0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_idle();
        obs_t e, o;
        reset_in = 1'b1;
        dma_req  = 1'b0;
        hold_fields = 1'b1;
        cpu_ma = 4'd3; cpu_ml = 4'd5; cpu_xa = 3'd2; cpu_xl = 4'd4; cpu_as = 3'd1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, K_CPU);
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("[TB] FAIL idle cycle %0d: got %h want %h", i, o, e);
            end
        end
        hold_fields = 1'b0;
    endtask

    task automatic test_burst4();
        obs_t e, o;
        int kind[$];
        bit req[$];
        dma_burst = 4'd3;
        kind = '{K_CPU, K_CPU, K_CPU, K_CPU, K_GAP, K_DMA, K_DMA, K_DMA, K_DONE,
                 K_GAP, K_CPU, K_CPU};
        req  = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        for (int i = 0; i < kind.size(); i++) begin
            drive_cycle(req[i], 1'b0, kind[i]);
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("[TB] FAIL burst4 cycle %0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_lock();
        obs_t e, o;
        int kind[$];
        bit req[$];
        bit lock[$];
        dma_burst = 4'd0;
        kind = '{K_CPU, K_CPU, K_CPU, K_CPU, K_CPU, K_CPU, K_CPU, K_CPU, K_CPU,
                 K_GAP, K_DONE, K_GAP, K_CPU};
        req  = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        lock = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        for (int i = 0; i < kind.size(); i++) begin
            drive_cycle(req[i], lock[i], kind[i]);
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("[TB] FAIL lock cycle %0d: got %h want %h", i, o, e);
            end
        end
    endtask

    // CPU window after a burst: CPU_MIN_CYCLES held cycles plus the arbitration cycle.
    task automatic test_back_to_back();
        obs_t e, o;
        int kind[$];
        bit req[$];
        dma_burst = 4'd1;
        kind = '{K_CPU, K_CPU, K_CPU, K_GAP, K_DMA, K_DONE, K_GAP, K_CPU, K_CPU, K_CPU,
                 K_GAP, K_DMA, K_DONE, K_GAP, K_CPU, K_CPU};
        req  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        for (int i = 0; i < kind.size(); i++) begin
            drive_cycle(req[i], 1'b0, kind[i]);
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("[TB] FAIL back_to_back cycle %0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_req_pulse();
        obs_t e, o;
        int kind[$];
        bit req[$];
        dma_burst = 4'd3;
        kind = '{K_CPU, K_CPU, K_CPU, K_CPU, K_GAP, K_DMA, K_GAP, K_CPU};
        req  = '{0, 0, 0, 1, 0, 0, 0, 0};
        for (int i = 0; i < kind.size(); i++) begin
            drive_cycle(req[i], 1'b0, kind[i]);
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("[TB] FAIL req_pulse cycle %0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_abort();
        obs_t e, o;
        int kind[$];
        bit req[$];
        dma_burst = 4'd7;
        kind = '{K_CPU, K_CPU, K_CPU, K_CPU, K_GAP, K_DMA, K_DMA, K_DMA, K_GAP, K_CPU, K_CPU};
        req  = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < kind.size(); i++) begin
            drive_cycle(req[i], 1'b0, kind[i]);
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("[TB] FAIL abort cycle %0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t e, o;
        int kind[$];
        bit req[$];
        dma_burst = 4'd5;
        kind = '{K_CPU, K_CPU, K_CPU, K_CPU, K_GAP, K_DMA, K_DMA};
        req  = '{0, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < kind.size(); i++) begin
            drive_cycle(req[i], 1'b0, kind[i]);
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("[TB] FAIL async_reset lead cycle %0d: got %h want %h", i, o, e);
            end
        end
        @(posedge clk);
        #1;
        sb.push_back(expect_of(K_DMA));
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("[TB] FAIL async_reset third_dma: got %h want %h", o, e);
        end
        #1;
        reset_in = 1'b0;
        #1;
        sb.push_back(expect_of(K_ZERO));
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("[TB] FAIL async_reset immediate: got %h want %h", o, e);
        end
        dma_burst = 4'd0;
        drive_cycle(1'b1, 1'b0, K_ZERO);
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("[TB] FAIL async_reset held: got %h want %h", o, e);
        end
        reset_in = 1'b1;
        dma_req  = 1'b0;
        kind = '{K_CPU, K_CPU, K_GAP, K_DONE, K_GAP, K_CPU};
        req  = '{0, 1, 1, 1, 0, 0};
        for (int i = 0; i < kind.size(); i++) begin
            drive_cycle(req[i], 1'b0, kind[i]);
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("[TB] FAIL async_reset after cycle %0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_max_burst();
        obs_t e, o;
        int kind[$];
        bit req[$];
        dma_burst = 4'd15;
        kind = '{K_CPU, K_CPU, K_CPU, K_CPU, K_GAP};
        req  = '{0, 0, 0, 1, 1};
        for (int i = 0; i < 15; i++) begin
            kind.push_back(K_DMA);
            req.push_back(1'b1);
        end
        kind.push_back(K_DONE); req.push_back(1'b1);
        kind.push_back(K_GAP);  req.push_back(1'b1);
        kind.push_back(K_CPU);  req.push_back(1'b0);
        kind.push_back(K_CPU);  req.push_back(1'b0);
        for (int i = 0; i < kind.size(); i++) begin
            drive_cycle(req[i], 1'b0, kind[i]);
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("[TB] FAIL max_burst cycle %0d: got %h want %h", i, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_burst4();
        test_lock();
        test_back_to_back();
        test_req_pulse();
        test_abort();
        test_async_reset();
        test_max_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
